// File: rtl/rf_pkg.sv
// Shared constants for the register-file write path: geometry of the 16x16
// register file and the writeback source identifiers.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;
  localparam int RF_CNT_W  = 8;

  localparam logic SRC_ALU  = 1'b0;
  localparam logic SRC_LOAD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids plus the
// one-bit priority pointer, which remembers the most recent winner.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (valid[0] && valid[1]) begin
        if (ptr) grant[0] = 1'b1;
        else     grant[1] = 1'b1;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= SRC_LOAD;
    end else if (|grant) begin
      ptr <= grant[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between ALU and load writeback, with a
// registered output stage and a saturating count of contended cycles.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_src,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] grant;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Address, data and source hold their last values when idle; only rf_we drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      last_src <= SRC_ALU;
    end else begin
      rf_we <= |grant;
      if (grant[1]) begin
        rf_waddr <= req1_addr;
        rf_wdata <= req1_data;
        last_src <= SRC_LOAD;
      end else if (grant[0]) begin
        rf_waddr <= req0_addr;
        rf_wdata <= req0_data;
        last_src <= SRC_ALU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contention_cnt <= '0;
    end else if (req0_valid && req1_valid && contention_cnt != CNT_MAX) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the write port.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        last_src;
  logic [7:0]  contention_cnt;

  int checks = 0;
  int failures = 0;

  // Model: who won most recently, what the write port shows, and the file contents.
  int m_last = 1;
  bit m_we = 0;
  int m_waddr = 0, m_wdata = 0, m_src = 0, m_cnt = 0;
  int m_mem[16];
  int t_mem[16];
  logic obs_r0, obs_r1;

  rf_write_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .last_src       (last_src),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(bit r, bit v0, bit v1);
    if (r || (!v0 && !v1)) return -1;
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  task automatic check_output();
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("last_src", last_src, m_src);
    check("contention_cnt", contention_cnt, m_cnt);
  endtask

  // One clock cycle: drive, check readys mid-cycle, clock, update model, check outputs.
  task automatic apply_stimulus(bit r, bit v0, int a0, int d0, bit v1, int a1, int d1);
    int g;
    bit cur_we;
    int cur_a, cur_d;
    reset = r;
    req0_valid = v0; req0_addr = a0[3:0]; req0_data = d0[15:0];
    req1_valid = v1; req1_addr = a1[3:0]; req1_data = d1[15:0];
    #3;
    g = model_grant(r, v0, v1);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    cur_we = rf_we; cur_a = rf_waddr; cur_d = rf_wdata;
    @(posedge clk);
    #1;
    if (cur_we && !r) t_mem[cur_a] = cur_d;
    if (m_we && !r) m_mem[m_waddr] = m_wdata;
    if (r) begin
      m_we = 0; m_waddr = 0; m_wdata = 0; m_src = 0; m_cnt = 0; m_last = 1;
    end else begin
      if (v0 && v1) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      m_we = (g >= 0);
      if (g == 0) begin
        m_waddr = a0 % 16; m_wdata = d0 % 65536; m_src = 0; m_last = 0;
      end else if (g == 1) begin
        m_waddr = a1 % 16; m_wdata = d1 % 65536; m_src = 1; m_last = 1;
      end
    end
    check_output();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0;
      t_mem[i] = 0;
    end

    // Reset held two cycles with both requests pending.
    apply_stimulus(1, 1, 1, 16'h0101, 1, 2, 16'h0202);
    apply_stimulus(1, 1, 1, 16'h0101, 1, 2, 16'h0202);
    check("t1_we", rf_we, 0);
    check("t1_cnt", contention_cnt, 0);

    // Single ALU write then idle.
    apply_stimulus(0, 1, 3, 16'h1234, 0, 0, 0);
    check("t2_ready0", obs_r0, 1);
    check("t2_we", rf_we, 1);
    check("t2_waddr", rf_waddr, 3);
    check("t2_wdata", rf_wdata, 16'h1234);
    check("t2_src", last_src, SRC_ALU);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check("t2_idle_we", rf_we, 0);
    check("t2_hold_wdata", rf_wdata, 16'h1234);

    // Continuous contention alternates after a fresh reset.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 16'h0011, 1, 2, 16'h0022);
    check("t3_g1", obs_r0, 1);
    apply_stimulus(0, 1, 1, 16'h0011, 1, 2, 16'h0022);
    check("t3_g2", obs_r1, 1);
    apply_stimulus(0, 1, 1, 16'h0011, 1, 2, 16'h0022);
    check("t3_g3", obs_r0, 1);
    check("t3_cnt", contention_cnt, 3);
    apply_stimulus(0, 1, 1, 16'h0011, 1, 2, 16'h0022);
    check("t3_g4", obs_r1, 1);

    // Same destination: winner first, loser's value lands last.
    apply_stimulus(0, 1, 5, 16'hAAAA, 1, 5, 16'hBBBB);
    check("t4_first", rf_wdata, 16'hAAAA);
    apply_stimulus(0, 0, 5, 16'hAAAA, 1, 5, 16'hBBBB);
    check("t4_second", rf_wdata, 16'hBBBB);
    check("t4_src", last_src, SRC_LOAD);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check("t4_rf5", t_mem[5], 16'hBBBB);

    // Counter saturation.
    for (int i = 0; i < 300; i++) apply_stimulus(0, 1, 7, i, 1, 8, i + 1);
    check("t5_sat", contention_cnt, 255);
    apply_stimulus(0, 1, 7, 1, 1, 8, 2);
    check("t5_hold", contention_cnt, 255);

    // Reset right after a grant clears the write and the pointer.
    apply_stimulus(0, 1, 9, 16'h0909, 0, 0, 0);
    apply_stimulus(1, 1, 9, 16'h0909, 1, 10, 16'h0A0A);
    check("t6_we", rf_we, 0);
    apply_stimulus(0, 1, 9, 16'h0909, 1, 10, 16'h0A0A);
    check("t6_tie_r0", obs_r0, 1);
    check("t6_tie_r1", obs_r1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 24) == 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 65535),
                     1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 65535));
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) check("rf_contents", t_mem[i], m_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
